decode_hazard_unit: RTL and testbench
=====================================

Name: decode_hazard_unit

Overview:
- Decode stage that consumes the fetch stage's instruction stream (instruction, PC_out, valid).
- Drives the fetch stage's control inputs: stall, flush, PC_sel, branch_target.
- Decodes 16-bit instructions, reads register operands, resolves branches/jumps in decode, detects load-use hazards, and registers decoded fields into the ID/EX pipeline register.
- Includes a replay buffer, because fetch drops valid for the cycle after a stall.

Parameters:
- DATA_W, 8, register data width.
- NUM_REGS, 8, register count; register address fixed at 3 bits.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high.
- instruction  in  16  from fetch.
- PC_in  in  8  fetch PC_out, address of instruction.
- valid_in  in  1  fetch valid.
- rs1_addr  out  3  register file read port A, combinational.
- rs2_addr  out  3  register file read port B, combinational.
- rs1_data  in  DATA_W  port A data; forwarding of ALU results is done outside this block.
- rs2_data  in  DATA_W  port B data.
- stall  out  1  to fetch, combinational.
- flush  out  1  to fetch, combinational.
- PC_sel  out  1  to fetch, combinational.
- branch_target  out  8  to fetch, combinational.
- ex_valid  out  1  ID/EX valid, registered.
- ex_opcode  out  4  registered.
- ex_rd  out  3  registered.
- ex_a  out  DATA_W  registered operand A.
- ex_b  out  DATA_W  registered operand B.
- ex_imm  out  8  sign-extended imm6, registered.
- ex_pc  out  8  registered.
- illegal_op  out  1  one-cycle pulse, registered.
- halted  out  1  high in HALTED state.

Behaviour:
- Encoding: op=[15:12].
  - R-type (1 ADD, 2 SUB, 3 AND, 4 OR): rd=[11:9], rs1=[8:6], rs2=[5:3].
  - I-type (5 ADDI, 6 LOAD): rd=[11:9], rs1=[8:6], imm6=[5:0].
  - 7 STORE: data reg [11:9], base [8:6], imm6=[5:0]; rs1_addr=[8:6], rs2_addr=[11:9].
  - 8 BEQ / 9 BNE: rs1=[11:9], rs2=[8:6], off6=[5:0].
  - A JMP: target=[7:0].
  - 0 NOP.
  - F HALT.
  - Any other opcode is illegal: treated as NOP, illegal_op pulses the next cycle.
- Current instruction = replay buffer when replay_pending=1; otherwise instruction/PC_in qualified by valid_in.
- States: RUN, STALL, HALTED. Reset state is RUN.
- Load-use hazard: ex_valid && ex_opcode==LOAD && ex_rd equals a register actually read by the current instruction.
  - ADDI/LOAD read rs1 only.
  - JMP, NOP and HALT read none.
- RUN with hazard:
  - stall=1; ID/EX gets a bubble (ex_valid=0).
  - Current instruction and PC are captured into the replay buffer; replay_pending set; go to STALL.
  - Branch/jump resolution is suppressed while stall=1.
- STALL:
  - stall=0; the buffered instruction is decoded and issued.
  - replay_pending cleared; go to RUN.
  - Fetch valid_in is 0 this cycle and is ignored.
- Branch resolution, on the issuing cycle with no hazard:
  - BEQ taken when rs1_data==rs2_data; BNE taken when they differ.
  - Taken target = PC+1+sext(off6), modulo 256.
  - JMP target = [7:0], always taken.
  - When taken: PC_sel=1, flush=1, branch_target=target for exactly one cycle.
  - Branch/jump instructions still issue to ID/EX with ex_valid=1 so EX can ignore them.
  - When not taken: PC_sel=0, flush=0, branch_target=0.
- Flushed slot: fetch delivers valid_in=0 the next cycle; that cycle produces a bubble with no hazard check.
- HALT:
  - Issues with ex_valid=1, then state goes to HALTED.
  - HALTED: stall=1 permanently, ex_valid=0, halted=1, all input ignored.
  - Only reset exits HALTED.
- ID/EX register:
  - ex_a=rs1_data; ex_b=rs2_data.
  - ex_imm = imm6 sign-extended to 8 bits.
  - ex_rd = [11:9] for R/I types, 0 otherwise.
- Reset (synchronous):
  - All registered outputs 0; replay buffer cleared; state RUN.
  - Combinational outputs therefore evaluate to 0.
  - Reset during STALL discards the replay.
- Priority: reset > HALTED > hazard stall > branch redirect > normal issue.

Test Plan:
- LOAD r1 at PC 0x10, then ADD r2,r1,r3 at 0x11 -> at ADD decode: stall=1, ex_valid=0. Next cycle (valid_in=0): ADD issues from replay with ex_pc=0x11, ex_rd=2.
- BEQ r1,r2,off6=0x3E at PC 0x20 with rs1_data=rs2_data=0x55 -> PC_sel=1, flush=1, branch_target=0x1F for one cycle. Next cycle ex_valid=0. Same case with data 0x55/0x56 -> PC_sel=0.
- JMP 0xFF at PC 0x40 -> branch_target=0xFF, PC_sel=1. BEQ taken at PC 0xFE with off6=0x01 -> target 0x00 (wrap).
- LOAD r4, then BNE r4,r0 -> stall first, no redirect in the stall cycle. Replay cycle resolves BNE with the new rs data.
- Opcode 0xB at PC 0x05 -> illegal_op=1 next cycle, ex_valid=1 with ex_opcode=0xB, no stall. HALT -> halted=1 and stall=1 for 20 cycles; assert reset -> halted=0, stall=0, all ex_* = 0.
- Assert reset in the STALL cycle -> next cycle ex_valid=0 and no replay issue.

Source files
------------

// File: rtl/decode_hazard_unit.sv
// Decode stage: decodes 16-bit instructions, reads operands, resolves
// branches/jumps early, stalls on load-use hazards (with a one-entry replay
// buffer, since fetch drops valid after a stall) and fills the ID/EX register.
module decode_hazard_unit #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [15:0]                 instruction,
  input  logic [7:0]                  PC_in,
  input  logic                        valid_in,
  output logic [$clog2(NUM_REGS)-1:0] rs1_addr,
  output logic [$clog2(NUM_REGS)-1:0] rs2_addr,
  input  logic [DATA_W-1:0]           rs1_data,
  input  logic [DATA_W-1:0]           rs2_data,
  output logic                        stall,
  output logic                        flush,
  output logic                        PC_sel,
  output logic [7:0]                  branch_target,
  output logic                        ex_valid,
  output logic [3:0]                  ex_opcode,
  output logic [$clog2(NUM_REGS)-1:0] ex_rd,
  output logic [DATA_W-1:0]           ex_a,
  output logic [DATA_W-1:0]           ex_b,
  output logic [7:0]                  ex_imm,
  output logic [7:0]                  ex_pc,
  output logic                        illegal_op,
  output logic                        halted
);

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ADD   = 4'h1;
  localparam logic [3:0] OP_SUB   = 4'h2;
  localparam logic [3:0] OP_AND   = 4'h3;
  localparam logic [3:0] OP_OR    = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_LOAD  = 4'h6;
  localparam logic [3:0] OP_STORE = 4'h7;
  localparam logic [3:0] OP_BEQ   = 4'h8;
  localparam logic [3:0] OP_BNE   = 4'h9;
  localparam logic [3:0] OP_JMP   = 4'hA;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [1:0] {RUN, STALL, HALTED} state_t;

  state_t      state, state_next;

  logic [15:0] replay_instr;
  logic [7:0]  replay_pc;
  logic        replay_pending;

  logic [15:0] cur_instr;
  logic [7:0]  cur_pc;
  logic        cur_valid;
  logic        active;

  logic [3:0]  op;
  logic        reads_rs1, reads_rs2;
  logic        is_rtype, is_itype, is_jmp, is_illegal;
  logic        hazard, issue, taken, operands_eq;
  logic [7:0]  off_ext;
  logic [7:0]  target;

  // Pick the instruction being decoded: the replayed one takes precedence over fetch
  always_comb begin
    if (replay_pending) begin
      cur_instr = replay_instr;
      cur_pc    = replay_pc;
      cur_valid = 1'b1;
    end else begin
      cur_instr = instruction;
      cur_pc    = PC_in;
      cur_valid = valid_in;
    end
  end

  assign op     = cur_instr[15:12];
  assign active = cur_valid && (state != HALTED);

  // Field decode and register read addresses; unread ports are parked at r0
  always_comb begin
    rs1_addr   = '0;
    rs2_addr   = '0;
    reads_rs1  = 1'b0;
    reads_rs2  = 1'b0;
    is_rtype   = 1'b0;
    is_itype   = 1'b0;
    is_jmp     = 1'b0;
    is_illegal = 1'b0;
    if (active) begin
      case (op)
        OP_ADD, OP_SUB, OP_AND, OP_OR: begin
          is_rtype  = 1'b1;
          reads_rs1 = 1'b1;
          reads_rs2 = 1'b1;
          rs1_addr  = cur_instr[8:6];
          rs2_addr  = cur_instr[5:3];
        end
        OP_ADDI, OP_LOAD: begin
          is_itype  = 1'b1;
          reads_rs1 = 1'b1;
          rs1_addr  = cur_instr[8:6];
        end
        OP_STORE: begin
          reads_rs1 = 1'b1;
          reads_rs2 = 1'b1;
          rs1_addr  = cur_instr[8:6];
          rs2_addr  = cur_instr[11:9];
        end
        OP_BEQ, OP_BNE: begin
          reads_rs1 = 1'b1;
          reads_rs2 = 1'b1;
          rs1_addr  = cur_instr[11:9];
          rs2_addr  = cur_instr[8:6];
        end
        OP_JMP:           is_jmp     = 1'b1;
        OP_NOP, OP_HALT:  is_illegal = 1'b0;
        default:          is_illegal = 1'b1;
      endcase
    end
  end

  // A load in EX whose destination we actually read forces a one-cycle stall
  assign hazard = active && (state == RUN) && ex_valid && (ex_opcode == OP_LOAD) &&
                  ((reads_rs1 && (ex_rd == rs1_addr)) || (reads_rs2 && (ex_rd == rs2_addr)));
  assign issue  = active && !hazard;

  assign operands_eq = (rs1_data == rs2_data);
  assign off_ext     = {{2{cur_instr[5]}}, cur_instr[5:0]};
  assign target      = is_jmp ? cur_instr[7:0] : (cur_pc + 8'd1 + off_ext);
  assign taken       = issue && (is_jmp || ((op == OP_BEQ) && operands_eq) ||
                                 ((op == OP_BNE) && !operands_eq));

  assign stall         = (state == HALTED) || hazard;
  assign flush         = taken;
  assign PC_sel        = taken;
  assign branch_target = taken ? target : 8'd0;
  assign halted        = (state == HALTED);

  // Next-state logic: hazard enters STALL, an issued HALT parks in HALTED
  always_comb begin
    state_next = state;
    unique case (state)
      RUN, STALL: begin
        if (hazard)                      state_next = STALL;
        else if (issue && op == OP_HALT) state_next = HALTED;
        else                             state_next = RUN;
      end
      HALTED:  state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= RUN;
    else       state <= state_next;
  end

  // ID/EX pipeline register and replay buffer
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_valid       <= 1'b0;
      ex_opcode      <= 4'd0;
      ex_rd          <= '0;
      ex_a           <= '0;
      ex_b           <= '0;
      ex_imm         <= 8'd0;
      ex_pc          <= 8'd0;
      illegal_op     <= 1'b0;
      replay_instr   <= 16'd0;
      replay_pc      <= 8'd0;
      replay_pending <= 1'b0;
    end else begin
      ex_valid   <= issue;
      illegal_op <= issue && is_illegal;
      if (issue) begin
        ex_opcode <= op;
        ex_rd     <= (is_rtype || is_itype) ? cur_instr[11:9] : '0;
        ex_a      <= rs1_data;
        ex_b      <= rs2_data;
        ex_imm    <= off_ext;
        ex_pc     <= cur_pc;
      end
      if (hazard) begin
        replay_instr   <= cur_instr;
        replay_pc      <= cur_pc;
        replay_pending <= 1'b1;
      end else begin
        replay_pending <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_decode_hazard_unit.sv
// Directed testbench for decode_hazard_unit with a combinational register file model.
module tb_decode_hazard_unit;

  logic        clk;
  logic        reset;
  logic [15:0] instruction;
  logic [7:0]  PC_in;
  logic        valid_in;
  logic [2:0]  rs1_addr, rs2_addr;
  logic [7:0]  rs1_data, rs2_data;
  logic        stall, flush, PC_sel;
  logic [7:0]  branch_target;
  logic        ex_valid;
  logic [3:0]  ex_opcode;
  logic [2:0]  ex_rd;
  logic [7:0]  ex_a, ex_b, ex_imm, ex_pc;
  logic        illegal_op, halted;

  logic [7:0]  rf [0:7];
  int          errors = 0;
  int          checks = 0;

  decode_hazard_unit #(.DATA_W(8), .NUM_REGS(8)) dut (
    .clk(clk), .reset(reset), .instruction(instruction), .PC_in(PC_in), .valid_in(valid_in),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rs1_data(rs1_data), .rs2_data(rs2_data),
    .stall(stall), .flush(flush), .PC_sel(PC_sel), .branch_target(branch_target),
    .ex_valid(ex_valid), .ex_opcode(ex_opcode), .ex_rd(ex_rd), .ex_a(ex_a), .ex_b(ex_b),
    .ex_imm(ex_imm), .ex_pc(ex_pc), .illegal_op(illegal_op), .halted(halted)
  );

  // Free-running clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register file reads are combinational
  assign rs1_data = rf[rs1_addr];
  assign rs2_data = rf[rs2_addr];

  function automatic logic [15:0] enc_r(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] s1, input logic [2:0] s2);
    return {op, rd, s1, s2, 3'b000};
  endfunction

  function automatic logic [15:0] enc_i(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] s1, input logic [5:0] imm);
    return {op, rd, s1, imm};
  endfunction

  function automatic logic [15:0] enc_b(input logic [3:0] op, input logic [2:0] s1,
                                        input logic [2:0] s2, input logic [5:0] off);
    return {op, s1, s2, off};
  endfunction

  task automatic drive(input logic [15:0] i, input logic [7:0] pc, input logic v);
    @(negedge clk);
    instruction = i;
    PC_in       = pc;
    valid_in    = v;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(16'h0000, 8'h00, 1'b0);
    tick();
    tick();
    drive(16'h0000, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_ex_valid got=%0h exp=0", ex_valid); end
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL reset_stall got=%0h exp=0", stall); end
    checks++; if (PC_sel !== 1'b0 || flush !== 1'b0) begin errors++; $display("[TB] FAIL reset_redirect got=%0h/%0h exp=0/0", PC_sel, flush); end
    checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted got=%0h exp=0", halted); end
    checks++; if (ex_opcode !== 4'h0 || ex_pc !== 8'h00) begin errors++; $display("[TB] FAIL reset_ex_fields got=%0h/%0h exp=0/0", ex_opcode, ex_pc); end
  endtask

  task automatic test_load_use();
    rf[1] = 8'h55; rf[3] = 8'h33;
    drive(enc_i(4'h6, 3'd1, 3'd0, 6'h00), 8'h10, 1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_load_stall got=%0h exp=0", stall); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'h6 || ex_rd !== 3'd1) begin errors++; $display("[TB] FAIL lu_load_issue got=%0h/%0h/%0h exp=1/6/1", ex_valid, ex_opcode, ex_rd); end
    drive(enc_r(4'h1, 3'd2, 3'd1, 3'd3), 8'h11, 1'b1);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lu_add_stall got=%0h exp=1", stall); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_bubble got=%0h exp=0", ex_valid); end
    drive(16'h0000, 8'h12, 1'b0);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL lu_replay_stall got=%0h exp=0", stall); end
    checks++; if (rs1_addr !== 3'd1 || rs2_addr !== 3'd3) begin errors++; $display("[TB] FAIL lu_replay_addr got=%0h/%0h exp=1/3", rs1_addr, rs2_addr); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_pc !== 8'h11 || ex_rd !== 3'd2) begin errors++; $display("[TB] FAIL lu_replay_issue got=%0h/%0h/%0h exp=1/11/2", ex_valid, ex_pc, ex_rd); end
    checks++; if (ex_opcode !== 4'h1 || ex_a !== 8'h55 || ex_b !== 8'h33) begin errors++; $display("[TB] FAIL lu_replay_data got=%0h/%0h/%0h exp=1/55/33", ex_opcode, ex_a, ex_b); end
    drive(16'h0000, 8'h13, 1'b0);
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL lu_idle got=%0h exp=0", ex_valid); end
  endtask

  task automatic test_branch();
    rf[1] = 8'h55; rf[2] = 8'h55;
    drive(enc_b(4'h8, 3'd1, 3'd2, 6'h3E), 8'h20, 1'b1);
    checks++; if (PC_sel !== 1'b1 || flush !== 1'b1) begin errors++; $display("[TB] FAIL beq_taken got=%0h/%0h exp=1/1", PC_sel, flush); end
    checks++; if (branch_target !== 8'h1F) begin errors++; $display("[TB] FAIL beq_target got=%0h exp=1f", branch_target); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'h8 || ex_rd !== 3'd0) begin errors++; $display("[TB] FAIL beq_issue got=%0h/%0h/%0h exp=1/8/0", ex_valid, ex_opcode, ex_rd); end
    checks++; if (ex_imm !== 8'hFE) begin errors++; $display("[TB] FAIL beq_imm got=%0h exp=fe", ex_imm); end
    drive(16'h0000, 8'h21, 1'b0);
    checks++; if (PC_sel !== 1'b0 || flush !== 1'b0 || branch_target !== 8'h00) begin errors++; $display("[TB] FAIL beq_one_cycle got=%0h/%0h/%0h exp=0/0/0", PC_sel, flush, branch_target); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL flushed_slot got=%0h exp=0", ex_valid); end
    rf[2] = 8'h56;
    drive(enc_b(4'h8, 3'd1, 3'd2, 6'h3E), 8'h20, 1'b1);
    checks++; if (PC_sel !== 1'b0 || flush !== 1'b0 || branch_target !== 8'h00) begin errors++; $display("[TB] FAIL beq_not_taken got=%0h/%0h/%0h exp=0/0/0", PC_sel, flush, branch_target); end
    tick();
    checks++; if (ex_valid !== 1'b1) begin errors++; $display("[TB] FAIL beq_nt_issue got=%0h exp=1", ex_valid); end
  endtask

  task automatic test_jump();
    drive({4'hA, 4'h0, 8'hFF}, 8'h40, 1'b1);
    checks++; if (PC_sel !== 1'b1 || branch_target !== 8'hFF) begin errors++; $display("[TB] FAIL jmp got=%0h/%0h exp=1/ff", PC_sel, branch_target); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'hA) begin errors++; $display("[TB] FAIL jmp_issue got=%0h/%0h exp=1/a", ex_valid, ex_opcode); end
    drive(enc_b(4'h8, 3'd1, 3'd1, 6'h01), 8'hFE, 1'b1);
    checks++; if (PC_sel !== 1'b1 || branch_target !== 8'h00) begin errors++; $display("[TB] FAIL beq_wrap got=%0h/%0h exp=1/00", PC_sel, branch_target); end
    tick();
  endtask

  task automatic test_load_branch();
    rf[4] = 8'h11; rf[0] = 8'h00;
    drive(16'h0000, 8'h00, 1'b0);
    tick();
    drive(enc_i(4'h6, 3'd4, 3'd0, 6'h00), 8'h30, 1'b1);
    tick();
    drive(enc_b(4'h9, 3'd4, 3'd0, 6'h05), 8'h31, 1'b1);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL lb_stall got=%0h exp=1", stall); end
    checks++; if (PC_sel !== 1'b0 || flush !== 1'b0) begin errors++; $display("[TB] FAIL lb_suppressed got=%0h/%0h exp=0/0", PC_sel, flush); end
    tick();
    rf[4] = 8'h77;
    drive(16'h0000, 8'h32, 1'b0);
    checks++; if (stall !== 1'b0 || PC_sel !== 1'b1 || branch_target !== 8'h37) begin errors++; $display("[TB] FAIL lb_replay_redirect got=%0h/%0h/%0h exp=0/1/37", stall, PC_sel, branch_target); end
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'h9 || ex_pc !== 8'h31 || ex_a !== 8'h77) begin errors++; $display("[TB] FAIL lb_replay_issue got=%0h/%0h/%0h/%0h exp=1/9/31/77", ex_valid, ex_opcode, ex_pc, ex_a); end
  endtask

  task automatic test_illegal();
    drive(16'h0000, 8'h00, 1'b0);
    tick();
    drive(16'hB000, 8'h05, 1'b1);
    checks++; if (stall !== 1'b0) begin errors++; $display("[TB] FAIL ill_stall got=%0h exp=0", stall); end
    tick();
    checks++; if (illegal_op !== 1'b1) begin errors++; $display("[TB] FAIL ill_pulse got=%0h exp=1", illegal_op); end
    checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'hB || ex_rd !== 3'd0) begin errors++; $display("[TB] FAIL ill_issue got=%0h/%0h/%0h exp=1/b/0", ex_valid, ex_opcode, ex_rd); end
    drive(16'h0000, 8'h06, 1'b0);
    tick();
    checks++; if (illegal_op !== 1'b0) begin errors++; $display("[TB] FAIL ill_one_cycle got=%0h exp=0", illegal_op); end
  endtask

  task automatic test_halt();
    drive(16'hF000, 8'h50, 1'b1);
    tick();
    checks++; if (ex_valid !== 1'b1 || ex_opcode !== 4'hF) begin errors++; $display("[TB] FAIL halt_issue got=%0h/%0h exp=1/f", ex_valid, ex_opcode); end
    checks++; if (halted !== 1'b1 || stall !== 1'b1) begin errors++; $display("[TB] FAIL halt_state got=%0h/%0h exp=1/1", halted, stall); end
    for (int c = 0; c < 20; c++) begin
      drive({4'hA, 4'h0, 8'h12}, 8'h60, 1'b1);
      tick();
      checks++; if (halted !== 1'b1 || stall !== 1'b1 || PC_sel !== 1'b0 || ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL halt_hold cycle=%0d got=%0h/%0h/%0h/%0h exp=1/1/0/0", c, halted, stall, PC_sel, ex_valid); end
    end
    drive(16'h0000, 8'h00, 1'b0);
    reset = 1'b1;
    tick();
    drive(16'h0000, 8'h00, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (halted !== 1'b0 || stall !== 1'b0) begin errors++; $display("[TB] FAIL halt_reset got=%0h/%0h exp=0/0", halted, stall); end
    checks++; if (ex_valid !== 1'b0 || ex_opcode !== 4'h0 || ex_rd !== 3'd0 || ex_a !== 8'h00 || ex_b !== 8'h00 || ex_imm !== 8'h00 || ex_pc !== 8'h00) begin
      errors++; $display("[TB] FAIL halt_reset_ex got=%0h/%0h/%0h/%0h/%0h/%0h/%0h exp=all 0", ex_valid, ex_opcode, ex_rd, ex_a, ex_b, ex_imm, ex_pc);
    end
  endtask

  task automatic test_reset_in_stall();
    rf[1] = 8'h55; rf[3] = 8'h33;
    drive(enc_i(4'h6, 3'd1, 3'd0, 6'h00), 8'h10, 1'b1);
    tick();
    drive(enc_r(4'h1, 3'd2, 3'd1, 3'd3), 8'h11, 1'b1);
    checks++; if (stall !== 1'b1) begin errors++; $display("[TB] FAIL ris_stall got=%0h exp=1", stall); end
    tick();
    drive(16'h0000, 8'h12, 1'b0);
    reset = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL ris_reset_cycle got=%0h exp=0", ex_valid); end
    drive(16'h0000, 8'h13, 1'b0);
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0 || rs1_addr !== 3'd0 || rs2_addr !== 3'd0) begin errors++; $display("[TB] FAIL ris_no_replay_decode got=%0h/%0h/%0h exp=0/0/0", stall, rs1_addr, rs2_addr); end
    tick();
    checks++; if (ex_valid !== 1'b0) begin errors++; $display("[TB] FAIL ris_no_replay_issue got=%0h exp=0", ex_valid); end
  endtask

  // Test sequence
  initial begin
    reset       = 1'b1;
    instruction = 16'h0000;
    PC_in       = 8'h00;
    valid_in    = 1'b0;
    for (int r = 0; r < 8; r++) rf[r] = 8'h00;
    test_reset();
    test_load_use();
    test_branch();
    test_jump();
    test_load_branch();
    test_illegal();
    test_halt();
    test_reset_in_stall();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
